// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: instruction field positions, widths and the bubble encoding.
package mips_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned JIDX_MSB   = 25;
  localparam int unsigned JIDX_LSB   = 0;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicer of a 32-bit MIPS instruction into its R/I/J-format fields.
module instr_field_split
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [25:0] jump_index
);

  assign opcode     = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs         = instr[RS_MSB:RS_LSB];
  assign rt         = instr[RT_MSB:RT_LSB];
  assign rd         = instr[RD_MSB:RD_LSB];
  assign shamt      = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct      = instr[FUNCT_MSB:FUNCT_LSB];
  assign jump_index = instr[JIDX_MSB:JIDX_LSB];

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with valid/ready on both sides and a one-entry skid buffer,
// so in_ready is registered and never combinationally depends on out_ready.
module if_id_stage_reg
  import mips_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned     ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc4,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc4,
  output logic [5:0]            opcode,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [4:0]            shamt,
  output logic [5:0]            funct,
  output logic [ADDR_WIDTH-1:0] immediate,
  output logic [25:0]           jump_index
);

  logic [DATA_WIDTH-1:0] main_instr_q, main_pc4_q, skid_instr_q, skid_pc4_q;
  logic                  main_valid_q, skid_valid_q;
  logic                  accept, drain;

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign drain     = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_instr = main_instr_q;
  assign out_pc4   = main_pc4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc4_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else if (flush) begin
      // Redirect: drop everything held or arriving; pc4 is deliberately left as-is.
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_instr_q <= skid_instr_q;
        main_pc4_q   <= skid_pc4_q;
        skid_valid_q <= 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      if (accept) begin
        main_valid_q <= 1'b1;
        main_instr_q <= in_instr;
        main_pc4_q   <= in_pc4;
      end else if (main_valid_q) begin
        main_valid_q <= 1'b0;
        main_instr_q <= NOP_INSTR;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_instr_q <= in_instr;
      skid_pc4_q   <= in_pc4;
    end
  end

  instr_field_split u_split (
    .instr      (main_instr_q[31:0]),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .jump_index (jump_index)
  );

  assign immediate = main_instr_q[ADDR_WIDTH-1:0];

endmodule
